// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a split-transaction memory port.
// Ports:
//   clock, reset                  - rising-edge clock, asynchronous active-high reset
//   Dmem2proc_response/data/tag   - memory acceptance tag, returned line, returned-line tag
//   proc2Dcache_addr/data/command/size - processor request (command 0 none, 1 load, 2 store)
//   proc2Dmem_command/addr/data   - memory request, combinational from state and latched request
//   Dcache_data_out/valid_out     - registered, zero-extended load result
//   finished                      - registered one-cycle completion pulse
//   show_dcache_data              - per-line {valid, dirty, tag, data}, TEST_MODE builds only
module dcache #(
   parameter int unsigned DCACHE_LINES = 32,
   parameter int unsigned XLEN         = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      Dmem2proc_response,
   input  logic [63:0]     Dmem2proc_data,
   input  logic [3:0]      Dmem2proc_tag,
   input  logic [XLEN-1:0] proc2Dcache_addr,
   input  logic [63:0]     proc2Dcache_data,
   input  logic [1:0]      proc2Dcache_command,
   input  logic [1:0]      proc2Dcache_size,
   output logic [1:0]      proc2Dmem_command,
   output logic [XLEN-1:0] proc2Dmem_addr,
   output logic [63:0]     proc2Dmem_data,
   output logic [63:0]     Dcache_data_out,
   output logic            Dcache_valid_out,
   output logic            finished
`ifdef TEST_MODE
   ,
   output logic [DCACHE_LINES-1:0][XLEN-$clog2(DCACHE_LINES)+62:0] show_dcache_data
`endif
);

   localparam int unsigned IDX_W = $clog2(DCACHE_LINES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 3;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   typedef enum logic [2:0] {IDLE, WB_REQ, LD_REQ, LD_WAIT, DONE} state_t;

   state_t state;

   // latched request
   logic [1:0]      req_cmd;
   logic [XLEN-1:0] req_addr;
   logic [63:0]     req_data;
   logic [1:0]      req_size;
   logic [3:0]      mem_tag;

   // line storage
   logic [DCACHE_LINES-1:0] line_valid;
   logic [DCACHE_LINES-1:0] line_dirty;
   logic [TAG_W-1:0]        line_tag  [DCACHE_LINES];
   logic [63:0]             line_data [DCACHE_LINES];

   logic [IDX_W-1:0] in_idx, rq_idx;
   logic [TAG_W-1:0] in_tag, rq_tag;
   logic             in_hit, in_access;

   assign in_idx    = proc2Dcache_addr[IDX_W+2:3];
   assign in_tag    = proc2Dcache_addr[XLEN-1:IDX_W+3];
   assign rq_idx    = req_addr[IDX_W+2:3];
   assign rq_tag    = req_addr[XLEN-1:IDX_W+3];
   assign in_hit    = line_valid[in_idx] && (line_tag[in_idx] == in_tag);
   assign in_access = (proc2Dcache_command == CMD_LOAD) || (proc2Dcache_command == CMD_STORE);

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Access datapath: a hit uses the live request and stored line, a fill uses the
   // latched request and the line arriving from memory. Bytes shifted past bit 63 drop out.
   logic [63:0] acc_line, acc_wdata, acc_mask, acc_load, acc_store;
   logic [2:0]  acc_off;
   logic [1:0]  acc_size;
   logic [5:0]  acc_sh;

   always_comb begin
      acc_line  = line_data[in_idx];
      acc_off   = proc2Dcache_addr[2:0];
      acc_size  = proc2Dcache_size;
      acc_wdata = proc2Dcache_data;
      if (state == LD_WAIT) begin
         acc_line  = Dmem2proc_data;
         acc_off   = req_addr[2:0];
         acc_size  = req_size;
         acc_wdata = req_data;
      end
      acc_mask  = size_mask(acc_size);
      acc_sh    = (acc_size == 2'd3) ? 6'd0 : {acc_off, 3'b000};
      acc_load  = (acc_line >> acc_sh) & acc_mask;
      acc_store = (acc_line & ~(acc_mask << acc_sh)) | ((acc_wdata & acc_mask) << acc_sh);
   end

   // Memory-side request
   always_comb begin
      proc2Dmem_command = CMD_NONE;
      proc2Dmem_addr    = '0;
      proc2Dmem_data    = '0;
      case (state)
         WB_REQ: begin
            proc2Dmem_command = CMD_STORE;
            proc2Dmem_addr    = {line_tag[rq_idx], rq_idx, 3'b000};
            proc2Dmem_data    = line_data[rq_idx];
         end
         LD_REQ: begin
            proc2Dmem_command = CMD_LOAD;
            proc2Dmem_addr    = {rq_tag, rq_idx, 3'b000};
         end
         default: ;
      endcase
   end

   // Controller, line storage and processor-side outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         req_cmd          <= '0;
         req_addr         <= '0;
         req_data         <= '0;
         req_size         <= '0;
         mem_tag          <= '0;
         line_valid       <= '0;
         line_dirty       <= '0;
         line_tag         <= '{default: '0};
         line_data        <= '{default: '0};
         Dcache_data_out  <= '0;
         Dcache_valid_out <= 1'b0;
         finished         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (proc2Dcache_command != CMD_NONE) begin
                  req_cmd  <= proc2Dcache_command;
                  req_addr <= proc2Dcache_addr;
                  req_data <= proc2Dcache_data;
                  req_size <= proc2Dcache_size;
               end
               if (in_access && !in_hit) begin
                  state <= (line_valid[in_idx] && line_dirty[in_idx]) ? WB_REQ : LD_REQ;
               end else begin
                  state            <= DONE;
                  finished         <= 1'b1;
                  Dcache_valid_out <= (proc2Dcache_command == CMD_LOAD);
                  Dcache_data_out  <= (proc2Dcache_command == CMD_LOAD) ? acc_load : '0;
                  if (proc2Dcache_command == CMD_STORE) begin
                     line_data[in_idx]  <= acc_store;
                     line_dirty[in_idx] <= 1'b1;
                  end
               end
            end
            WB_REQ: begin
               if (Dmem2proc_response != 4'd0) begin
                  line_dirty[rq_idx] <= 1'b0;
                  state              <= LD_REQ;
               end
            end
            LD_REQ: begin
               if (Dmem2proc_response != 4'd0) begin
                  mem_tag <= Dmem2proc_response;
                  state   <= LD_WAIT;
               end
            end
            LD_WAIT: begin
               // fill and access land on the same edge
               if ((Dmem2proc_tag == mem_tag) && (mem_tag != 4'd0)) begin
                  mem_tag            <= '0;
                  line_valid[rq_idx] <= 1'b1;
                  line_tag[rq_idx]   <= rq_tag;
                  line_data[rq_idx]  <= (req_cmd == CMD_STORE) ? acc_store : Dmem2proc_data;
                  line_dirty[rq_idx] <= (req_cmd == CMD_STORE);
                  state              <= DONE;
                  finished           <= 1'b1;
                  Dcache_valid_out   <= (req_cmd == CMD_LOAD);
                  Dcache_data_out    <= (req_cmd == CMD_LOAD) ? acc_load : '0;
               end
            end
            DONE: begin
               finished         <= 1'b0;
               Dcache_valid_out <= 1'b0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TEST_MODE
   for (genvar g = 0; g < DCACHE_LINES; g++) begin : g_show
      assign show_dcache_data[g] = {line_valid[g], line_dirty[g], line_tag[g], line_data[g]};
   end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random loads/stores against
// a byte-level cache/memory model, with an in-bench memory that can stall requests.
`timescale 1ns/1ps
module tb_dcache;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  Dmem2proc_response;
   logic [63:0] Dmem2proc_data;
   logic [3:0]  Dmem2proc_tag;
   logic [31:0] proc2Dcache_addr;
   logic [63:0] proc2Dcache_data;
   logic [1:0]  proc2Dcache_command;
   logic [1:0]  proc2Dcache_size;
   logic [1:0]  proc2Dmem_command;
   logic [31:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data;
   logic [63:0] Dcache_data_out;
   logic        Dcache_valid_out;
   logic        finished;
`ifdef TEST_MODE
   logic [31:0][89:0] show_dcache_data;
`endif

   always #5 clock = ~clock;

   dcache #(.DCACHE_LINES(32), .XLEN(32)) dut (
      .clock               (clock),
      .reset               (reset),
      .Dmem2proc_response  (Dmem2proc_response),
      .Dmem2proc_data      (Dmem2proc_data),
      .Dmem2proc_tag       (Dmem2proc_tag),
      .proc2Dcache_addr    (proc2Dcache_addr),
      .proc2Dcache_data    (proc2Dcache_data),
      .proc2Dcache_command (proc2Dcache_command),
      .proc2Dcache_size    (proc2Dcache_size),
      .proc2Dmem_command   (proc2Dmem_command),
      .proc2Dmem_addr      (proc2Dmem_addr),
      .proc2Dmem_data      (proc2Dmem_data),
      .Dcache_data_out     (Dcache_data_out),
      .Dcache_valid_out    (Dcache_valid_out),
      .finished            (finished)
`ifdef TEST_MODE
      ,
      .show_dcache_data    (show_dcache_data)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_valid [32];
   logic        m_dirty [32];
   logic [23:0] m_tag   [32];
   logic [63:0] m_data  [32];
   logic [63:0] mem [logic [31:0]];
   logic [3:0]  tag_ctr = 4'd0;

   function automatic logic [63:0] mem_read(input logic [31:0] line);
      if (mem.exists(line)) return mem[line];
      return {line ^ 32'hA5A5_0000, ~line};
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] line, input logic [2:0] off_in,
                                              input logic [1:0] size);
      logic [63:0] res = '0;
      int off = (size == 2'd3) ? 0 : int'(off_in);
      for (int i = 0; i < (1 << size); i++)
         if (off + i < 8) res[8*i +: 8] = line[8*(off+i) +: 8];
      return res;
   endfunction

   function automatic logic [63:0] model_store(input logic [63:0] line, input logic [2:0] off_in,
                                               input logic [1:0] size, input logic [63:0] wd);
      logic [63:0] res = line;
      int off = (size == 2'd3) ? 0 : int'(off_in);
      for (int i = 0; i < (1 << size); i++)
         if (off + i < 8) res[8*(off+i) +: 8] = wd[8*i +: 8];
      return res;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
   endfunction

   function automatic logic [3:0] next_tag();
      tag_ctr = (tag_ctr == 4'd15) ? 4'd1 : tag_ctr + 4'd1;
      return tag_ctr;
   endfunction

   task automatic chk_line(input string name, input logic [4:0] idx);
`ifdef TEST_MODE
      chk({name, " line"}, 128'(show_dcache_data[idx]),
          128'({m_valid[idx], m_dirty[idx], m_tag[idx], m_data[idx]}));
`else
      if (idx == 5'd31) chk({name, " idx"}, 128'(idx), 128'(5'd31));
`endif
   endtask

   // Wait for the idle NONE-cycle pulse, then land on a negedge where the DUT is in IDLE.
   task automatic sync_idle();
      int n = 0;
      while (!finished && n < 10) begin @(negedge clock); n++; end
      chk("sync finished", 128'(finished), 128'(1'b1));
      @(negedge clock);
   endtask

   // One processor operation, entered at a negedge with the DUT in IDLE.
   task automatic do_op(input string name, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [1:0] size, input logic [63:0] wdata, input int stall);
      logic [4:0]  idx;
      logic [23:0] tg;
      logic        is_acc, miss, exp_wb, saw_wb, saw_ld, done;
      logic [31:0] wb_addr, ld_addr;
      logic [63:0] wb_data, exp_out;
      logic [3:0]  pend, t;
      int          cycles, stall_left, ret_cnt;

      idx     = addr[7:3];
      tg      = addr[31:8];
      is_acc  = (cmd == 2'd1) || (cmd == 2'd2);
      miss    = is_acc && !(m_valid[idx] && m_tag[idx] == tg);
      exp_wb  = miss && m_valid[idx] && m_dirty[idx];
      wb_addr = {m_tag[idx], idx, 3'b000};
      wb_data = m_data[idx];
      ld_addr = {tg, idx, 3'b000};
      if (miss) begin
         if (exp_wb) mem[wb_addr >> 3] = wb_data;
         m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg;
         m_data[idx]  = mem_read(ld_addr >> 3);
      end
      exp_out = '0;
      if (cmd == 2'd1) exp_out = model_load(m_data[idx], addr[2:0], size);
      if (cmd == 2'd2) begin
         m_data[idx]  = model_store(m_data[idx], addr[2:0], size, wdata);
         m_dirty[idx] = 1'b1;
      end

      proc2Dcache_command = cmd;
      proc2Dcache_addr    = addr;
      proc2Dcache_size    = size;
      proc2Dcache_data    = wdata;

      cycles = 0; done = 0; saw_wb = 0; saw_ld = 0; stall_left = stall; ret_cnt = 0; pend = '0;
      while (!done && cycles < 60) begin
         @(posedge clock); cycles++;
         @(negedge clock);
         // the latched request must not follow these changes
         proc2Dcache_command = 2'd0;
         proc2Dcache_addr    = $urandom;
         proc2Dcache_data    = {$urandom, $urandom};
         proc2Dcache_size    = 2'($urandom_range(0, 3));
         Dmem2proc_response  = 4'd0;
         Dmem2proc_tag       = 4'd0;
         if (finished) begin
            done = 1;
         end else begin
            if (ret_cnt > 0) begin
               ret_cnt--;
               // a non-matching tag while waiting, then the real one
               Dmem2proc_tag = (pend == 4'd15) ? 4'd1 : pend + 4'd1;
               if (ret_cnt == 0) begin
                  Dmem2proc_tag  = pend;
                  Dmem2proc_data = mem_read(ld_addr >> 3);
               end
            end
            if (proc2Dmem_command == 2'd2) begin
               chk({name, " wb expected"}, 128'(1'b1), 128'(exp_wb && !saw_wb));
               chk({name, " wb addr"}, 128'(proc2Dmem_addr), 128'(wb_addr));
               chk({name, " wb data"}, 128'(proc2Dmem_data), 128'(wb_data));
               if (stall_left > 0) stall_left--;
               else begin
                  Dmem2proc_response = next_tag(); saw_wb = 1; stall_left = stall;
               end
            end else if (proc2Dmem_command == 2'd1) begin
               chk({name, " ld expected"}, 128'(1'b1), 128'(miss && !saw_ld));
               chk({name, " ld after wb"}, 128'(saw_wb), 128'(exp_wb));
               chk({name, " ld addr"}, 128'(proc2Dmem_addr), 128'(ld_addr));
               if (stall_left > 0) stall_left--;
               else begin
                  t = next_tag();
                  Dmem2proc_response = t; pend = t; ret_cnt = 2; saw_ld = 1; stall_left = stall;
               end
            end else if (proc2Dmem_command != 2'd0) begin
               chk({name, " mem cmd"}, 128'(proc2Dmem_command), 128'(2'd0));
            end
         end
      end
      chk({name, " finished"}, 128'(done), 128'(1'b1));
      if (!miss) chk({name, " hit latency"}, 128'(cycles), 128'(1));
      chk({name, " load issued"}, 128'(saw_ld), 128'(miss));
      chk({name, " wb issued"}, 128'(saw_wb), 128'(exp_wb));
      chk({name, " valid_out"}, 128'(Dcache_valid_out), 128'(cmd == 2'd1));
      if (cmd == 2'd1) chk({name, " data_out"}, 128'(Dcache_data_out), 128'(exp_out));
      chk_line(name, idx);
      @(negedge clock);
      chk({name, " finished pulse"}, 128'(finished), 128'(1'b0));
      chk({name, " idle mem cmd"}, 128'(proc2Dmem_command), 128'(2'd0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      logic [3:0]  t;
      int          n;
      logic        acc;

      reset = 1'b1;
      Dmem2proc_response = '0; Dmem2proc_data = '0; Dmem2proc_tag = '0;
      proc2Dcache_addr = '0; proc2Dcache_data = '0; proc2Dcache_command = '0; proc2Dcache_size = '0;
      model_reset();
      mem[32'd0] = 64'h0123_4567_89AB_CDEF;

      #12;
      chk("reset finished",  128'(finished),          128'(1'b0));
      chk("reset valid_out", 128'(Dcache_valid_out),  128'(1'b0));
      chk("reset data_out",  128'(Dcache_data_out),   128'(64'd0));
      chk("reset mem cmd",   128'(proc2Dmem_command), 128'(2'd0));
      chk("reset mem addr",  128'(proc2Dmem_addr),    128'(32'd0));
      @(negedge clock);
      reset = 1'b0;
      sync_idle();

      do_op("ld1 miss", 2'd1, 32'h0000_0001, 2'd0, 64'd0, 0);
      chk("ld1 byte", 128'(Dcache_data_out), 128'(64'hCD));
      do_op("st4 hit", 2'd2, 32'h0000_0004, 2'd1, 64'h0000_0000_0000_BEEF, 0);
      do_op("ld256 wb", 2'd1, 32'h0000_0100, 2'd2, 64'd0, 0);
      do_op("none", 2'd0, 32'h0000_0100, 2'd0, 64'd0, 0);
      do_op("st7 edge", 2'd2, 32'h0000_0107, 2'd2, 64'hAABB_CCDD, 0);
      do_op("ld6 edge", 2'd1, 32'h0000_0106, 2'd2, 64'd0, 0);
      do_op("ld dbl off", 2'd1, 32'h0000_0105, 2'd3, 64'd0, 0);
      do_op("ld stall", 2'd1, 32'h0000_122B, 2'd1, 64'd0, 3);
      do_op("st wb stall", 2'd2, 32'h0000_0001, 2'd0, 64'h77, 2);

      for (int i = 0; i < 40; i++) begin
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 3)
             | 32'($urandom_range(0, 7));
         do_op("rand", 2'($urandom_range(0, 2)), a, 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, $urandom_range(0, 2));
      end

      // reset while waiting for a fill
      proc2Dcache_command = 2'd1; proc2Dcache_addr = 32'h0000_5548; proc2Dcache_size = 2'd3;
      n = 0; acc = 0; t = '0;
      while (!acc && n < 20) begin
         @(posedge clock); @(negedge clock); n++;
         proc2Dcache_command = 2'd0;
         Dmem2proc_response  = 4'd0;
         if (proc2Dmem_command != 2'd0) begin
            t = next_tag(); Dmem2proc_response = t; acc = (proc2Dmem_command == 2'd1);
         end
      end
      chk("rst ld accepted", 128'(acc), 128'(1'b1));
      @(negedge clock);
      Dmem2proc_response = 4'd0;
      reset = 1'b1;
      #1;
      chk("rst mid finished",  128'(finished),          128'(1'b0));
      chk("rst mid valid_out", 128'(Dcache_valid_out),  128'(1'b0));
      chk("rst mid data_out",  128'(Dcache_data_out),   128'(64'd0));
      chk("rst mid mem cmd",   128'(proc2Dmem_command), 128'(2'd0));
      chk("rst mid mem data",  128'(proc2Dmem_data),    128'(64'd0));
      model_reset();
`ifdef TEST_MODE
      for (int i = 0; i < 32; i++) chk("rst mid line", 128'(show_dcache_data[i]), 128'(0));
`endif
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      Dmem2proc_tag = t; Dmem2proc_data = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clock);
      Dmem2proc_tag = 4'd0;
      sync_idle();
      chk_line("rst late tag", 5'd9);
      do_op("rst reload", 2'd1, 32'h0000_5548, 2'd3, 64'd0, 0);
      do_op("rst line0", 2'd1, 32'h0000_0000, 2'd3, 64'd0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
